// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lu_pkg
//  Purpose : Shared definitions for the logic-unit accumulator stage:
//            command codes, FSM state encoding and small helper functions
//            used by the write-back path.
//  Ports   : (package - no ports)
//  Rev     : 1.0  initial release
// ============================================================================
package lu_pkg;

  localparam int LU_DW = 8;

  // Command codes. Bits [1:0] of the logic commands are wired straight to
  // the logic unit's select inputs {s1,s0}, so their values are not free.
  localparam logic [2:0] CMD_OR   = 3'b000;
  localparam logic [2:0] CMD_XOR  = 3'b001;
  localparam logic [2:0] CMD_AND  = 3'b010;
  localparam logic [2:0] CMD_NOT  = 3'b011;
  localparam logic [2:0] CMD_LOAD = 3'b100;
  localparam logic [2:0] CMD_CLR  = 3'b101;
  localparam logic [2:0] CMD_READ = 3'b110;
  localparam logic [2:0] CMD_RSVD = 3'b111;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Write-back selection around the logic unit. Any command with bit 2
  // clear is a logic operation whose result is already on lu_res.
  function automatic logic [LU_DW-1:0] f_writeback(
    input logic [2:0]       cmd,
    input logic [LU_DW-1:0] lu_res,
    input logic [LU_DW-1:0] data,
    input logic [LU_DW-1:0] acc
  );
    logic [LU_DW-1:0] res;
    res = acc;
    case (cmd)
      CMD_OR, CMD_XOR, CMD_AND, CMD_NOT: res = lu_res;
      CMD_LOAD:                          res = data;
      CMD_CLR:                           res = '0;
      CMD_READ, CMD_RSVD:                res = acc;
      default:                           res = acc;
    endcase
    return res;
  endfunction

  // Odd parity indicator: 1 when the vector holds an odd number of ones.
  function automatic logic f_parity(input logic [LU_DW-1:0] v);
    return ^v;
  endfunction

endpackage : lu_pkg
`default_nettype wire

// File: rtl/logicunit8bit.sv
`default_nettype none
// ============================================================================
//  Module  : logicunit8bit
//  Purpose : Combinational 8-bit logic unit.
//            {s1,s0} = 00 : z = x | y
//                      01 : z = x ^ y
//                      10 : z = x & y
//                      11 : z = ~x      (y ignored)
//  Ports   : x, y   - 8-bit operands
//            s0, s1 - operation select
//            z      - 8-bit result
//  Rev     : 1.0  initial release
// ============================================================================
module logicunit8bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       s0,
  input  logic       s1,
  output logic [7:0] z
);

  always_comb begin
    z = '0;
    case ({s1, s0})
      2'b00:   z = x | y;
      2'b01:   z = x ^ y;
      2'b10:   z = x & y;
      2'b11:   z = ~x;
      default: z = '0;
    endcase
  end

endmodule : logicunit8bit
`default_nettype wire

// File: rtl/logic_acc8.sv
`default_nettype none
// ============================================================================
//  Module  : logic_acc8
//  Purpose : Sequenced accumulator around logicunit8bit. Accepts one
//            command at a time over a valid/ready handshake, applies it to
//            the accumulator (logic ops, LOAD, CLEAR, READ) and returns the
//            new accumulator value with zero/parity flags over a second
//            valid/ready handshake. Three-state sequencer: IDLE -> EXEC ->
//            RESP, so at most one command is in flight.
//  Ports   : clk, rst_n          - clock, async active-low reset
//            in_valid/in_ready   - command handshake
//            in_cmd, in_data     - command code and operand
//            out_valid/out_ready - response handshake
//            out_data            - result (new accumulator value)
//            out_zero            - out_data == 0
//            out_parity          - XOR of out_data bits
//            acc                 - current accumulator
//            op_count            - completed commands, wraps at 256
//  Rev     : 1.0  initial release
// ============================================================================
module logic_acc8
  import lu_pkg::*;
#(
  parameter int DW = 8   // datapath width; the logic unit is 8-bit only
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_cmd,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_zero,
  output logic          out_parity,
  output logic [DW-1:0] acc,
  output logic [7:0]    op_count
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic          r_in_ready;
  logic [2:0]    r_cmd_q;
  logic [DW-1:0] r_data_q;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_out_data;
  logic          r_out_zero;
  logic          r_out_parity;
  logic          r_out_valid;
  logic [7:0]    r_op_count;

  logic [1:0]    w_state_nxt;
  logic          w_in_fire;
  logic          w_out_fire;
  logic [DW-1:0] w_lu_res;
  logic [DW-1:0] w_wb_res;

  // r_in_ready is only ever set while in IDLE, so it alone qualifies a
  // transfer; commands offered in EXEC/RESP are never seen.
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Logic unit: x is the accumulator, y the latched operand.
  // --------------------------------------------------------------------------
  logicunit8bit u_lu (
    .x  (r_acc),
    .y  (r_data_q),
    .s0 (r_cmd_q[0]),
    .s1 (r_cmd_q[1]),
    .z  (w_lu_res)
  );

  assign w_wb_res = f_writeback(r_cmd_q, w_lu_res, r_data_q, r_acc);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_in_fire)  w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_out_fire) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_cmd_q      <= '0;
      r_data_q     <= '0;
      r_acc        <= '0;
      r_out_data   <= '0;
      r_out_zero   <= 1'b1;  // consistent with out_data == 0
      r_out_parity <= 1'b0;
      r_out_valid  <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Registered ready: held low through reset and for the first cycle
      // after release, then tracks "next state is IDLE".
      r_in_ready <= (w_state_nxt == ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_cmd_q  <= in_cmd;
            r_data_q <= in_data;
          end
        end

        ST_EXEC: begin
          r_acc        <= w_wb_res;
          r_out_data   <= w_wb_res;
          // Flags come from the same value that is registered as out_data.
          r_out_zero   <= (w_wb_res == '0);
          r_out_parity <= f_parity(w_wb_res);
          r_out_valid  <= 1'b1;
          r_op_count   <= r_op_count + 8'd1;
        end

        ST_RESP: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_zero   = r_out_zero;
  assign out_parity = r_out_parity;
  assign acc        = r_acc;
  assign op_count   = r_op_count;

endmodule : logic_acc8
`default_nettype wire

// File: tb/tb_logic_acc8.sv
`default_nettype none
// ============================================================================
//  Module  : tb_logic_acc8
//  Purpose : Directed self-checking bench for logic_acc8.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_logic_acc8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_cmd;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_parity;
  logic [7:0] acc;
  logic [7:0] op_count;

  int         n_assert;
  int         n_fail;
  logic [7:0] exp_cnt;

  localparam logic [2:0] C_OR   = 3'b000;
  localparam logic [2:0] C_XOR  = 3'b001;
  localparam logic [2:0] C_AND  = 3'b010;
  localparam logic [2:0] C_NOT  = 3'b011;
  localparam logic [2:0] C_LOAD = 3'b100;
  localparam logic [2:0] C_CLR  = 3'b101;
  localparam logic [2:0] C_READ = 3'b110;
  localparam logic [2:0] C_RSVD = 3'b111;

  logic_acc8 #(.DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .acc        (acc),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a falling edge. Issues one command, checks
  // the one-cycle EXEC latency and the response. With out_ready high the
  // response is consumed before returning; with out_ready low the task
  // returns while the response is being held.
  task automatic issue(input string tag, input logic [2:0] cmd, input logic [7:0] data,
                       input logic [7:0] exp_res, input logic exp_zero, input logic exp_par);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, 8'(n < 50), 8'd1);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_cmd   = 3'b000;
    in_data  = 8'h00;
    exp_cnt  = exp_cnt + 8'd1;
    @(negedge clk);
    chk({tag, "_exec_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_exec_ready"}, 8'(in_ready), 8'd0);
    @(negedge clk);
    chk({tag, "_valid"},  8'(out_valid),  8'd1);
    chk({tag, "_data"},   out_data,       exp_res);
    chk({tag, "_zero"},   8'(out_zero),   8'(exp_zero));
    chk({tag, "_parity"}, 8'(out_parity), 8'(exp_par));
    chk({tag, "_acc"},    acc,            exp_res);
    chk({tag, "_count"},  op_count,       exp_cnt);
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    logic seen;
    n_assert  = 0;
    n_fail    = 0;
    exp_cnt   = 8'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cmd    = 3'b000;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   8'(in_ready),   8'd0);
    chk("rst_out_valid",  8'(out_valid),  8'd0);
    chk("rst_out_data",   out_data,       8'h00);
    chk("rst_out_zero",   8'(out_zero),   8'd1);
    chk("rst_out_parity", 8'(out_parity), 8'd0);
    chk("rst_acc",        acc,            8'h00);
    chk("rst_op_count",   op_count,       8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 8'(in_ready), 8'd1);

    // ---------------- op_count wrap: 1 LOAD + 255 READs ----------------
    issue("wrap_load", C_LOAD, 8'h6C, 8'h6C, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++)
      issue("wrap_read", C_READ, 8'h5A, 8'h6C, 1'b0, 1'b0);
    chk("wrap_count", op_count, 8'h00);
    chk("wrap_acc",   acc,      8'h6C);

    // ---------------- logic operations ----------------
    issue("or_load",  C_LOAD, 8'h6C, 8'h6C, 1'b0, 1'b0);
    issue("or",       C_OR,   8'h17, 8'h7F, 1'b0, 1'b1);
    issue("and_load", C_LOAD, 8'h6C, 8'h6C, 1'b0, 1'b0);
    issue("and",      C_AND,  8'h17, 8'h04, 1'b0, 1'b1);
    issue("xor_load", C_LOAD, 8'h6C, 8'h6C, 1'b0, 1'b0);
    issue("xor",      C_XOR,  8'h17, 8'h7B, 1'b0, 1'b0);
    issue("not_load", C_LOAD, 8'h6C, 8'h6C, 1'b0, 1'b0);
    issue("not",      C_NOT,  8'h17, 8'h93, 1'b0, 1'b0);

    // ---------------- zero result, READ, CLEAR, reserved ----------------
    issue("z_load", C_LOAD, 8'hAA, 8'hAA, 1'b0, 1'b0);
    issue("z_xor",  C_XOR,  8'hAA, 8'h00, 1'b1, 1'b0);
    issue("z_read", C_READ, 8'hFF, 8'h00, 1'b1, 1'b0);
    issue("c_load", C_LOAD, 8'h01, 8'h01, 1'b0, 1'b1);
    issue("clr",    C_CLR,  8'hFF, 8'h00, 1'b1, 1'b0);
    issue("r_load", C_LOAD, 8'h5A, 8'h5A, 1'b0, 1'b0);
    issue("rsvd",   C_RSVD, 8'h0F, 8'h5A, 1'b0, 1'b0);

    // ---------------- back-pressure ----------------
    issue("bp_load", C_LOAD, 8'h6C, 8'h6C, 1'b0, 1'b0);
    out_ready = 1'b0;
    issue("bp_or", C_OR, 8'h11, 8'h7D, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_cmd   = C_LOAD;
      in_data  = 8'h00;
      @(negedge clk);
      chk("bp_valid",    8'(out_valid),  8'd1);
      chk("bp_data",     out_data,       8'h7D);
      chk("bp_parity",   8'(out_parity), 8'd0);
      chk("bp_in_ready", 8'(in_ready),   8'd0);
      chk("bp_acc",      acc,            8'h7D);
      chk("bp_count",    op_count,       exp_cnt);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 8'(out_valid), 8'd0);
    issue("bp_after", C_XOR, 8'h0F, 8'h72, 1'b0, 1'b0);

    // ---------------- reset abort during EXEC ----------------
    in_valid = 1'b1;
    in_cmd   = C_LOAD;
    in_data  = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_acc",      acc,           8'h00);
    chk("abort_valid",    8'(out_valid), 8'd0);
    chk("abort_in_ready", 8'(in_ready),  8'd0);
    chk("abort_count",    op_count,      8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_in_ready", 8'(in_ready),  8'd1);
    chk("abort_rel_acc",      acc,           8'h00);
    chk("abort_rel_valid",    8'(out_valid), 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_response", 8'(seen), 8'd0);
    exp_cnt = 8'd0;
    issue("abort_next", C_LOAD, 8'h3C, 8'h3C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_logic_acc8
`default_nettype wire
